lc3_offset_addr_arbiter: RTL and testbench
==========================================

# lc3_offset_addr_arbiter

Shared address-generation unit for the LC-3 datapath. It sign-extends an instruction offset field (imm5, offset6, PCoffset9 or PCoffset11) to 16 bits and adds it to a 16-bit base. The one extender/adder pair is time-shared between two requesters: requester 0 is the PC/branch unit and requester 1 is the load/store unit. A 3-state FSM sequences each operation, and a round-robin arbiter grants access.

## Interface
- `DATA_W`, 16, width of base, extended offset and result; the design is only defined for 16.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `r0_req`  in  1  requester 0 request; held high until `r0_ack`.
- `r0_base`  in  16  requester 0 base operand.
- `r0_off`  in  11  requester 0 raw offset field, LSB-aligned.
- `r0_sel`  in  2  requester 0 width select: 00 imm5, 01 offset6, 10 PCoffset9, 11 PCoffset11.
- `r0_ack`  out  1  one-cycle grant pulse to requester 0.
- `r1_req`, `r1_base`, `r1_off`, `r1_sel`, `r1_ack`: identical set for requester 1.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `res`  out  16  sum of base and sign-extended offset.
- `res_valid`  out  1  one-cycle pulse; `res` and `res_id` are valid in that cycle.
- `res_id`  out  1  index of the requester that owns `res`.
- `res_ovf`  out  1  signed-overflow flag; present only with the macro below.

## Operation
- FSM states: IDLE, EXT, ADD.
- **IDLE**
  - If any `req` is high at a clock edge, pick a winner.
  - Latch the winner's base, off, sel and id.
  - Assert that requester's `ack` for the next cycle.
  - Go to EXT.
- **EXT**
  - Register `ext` = `off` sign-extended from bit 4, 5, 8 or 10, selected by `sel`.
  - Offset bits above the selected field are ignored.
  - Clear `ack`. Go to ADD.
- **ADD**
  - Register `res` = base + `ext`, modulo 2^16, with no carry out.
  - Set `res_valid` = 1 and `res_id` = latched id.
  - Go to IDLE.
- **Outside IDLE**
  - `req` lines are not sampled.
  - A requester drops `req` in the cycle after seeing `ack`.
- **Arbitration**
  - Round-robin on a 1-bit `last` pointer.
  - If both `req` lines are high, the requester not equal to `last` wins.
  - If only one is high, it wins regardless of `last`.
  - `last` updates on every grant.
- **Operand stability**
  - Operands are captured at the grant edge.
  - Later changes to `base`/`off`/`sel`, or `req` dropping early, do not affect the operation in flight. It completes normally.
- **Reset**
  - Asynchronous, effective at any time, including mid-operation.
  - On reset: state = IDLE, `last` = 1 (requester 0 wins the first tie), and all outputs = 0 (`ack`s, `busy`, `res`, `res_valid`, `res_id`, `res_ovf`).
  - The in-flight operation is discarded; no `res_valid` is produced for it.

## Timing
- Edge e0: `req` sampled in IDLE. After e0: `ack` = 1, `busy` = 1.
- Edge e1: EXT completes. After e1: `ack` = 0.
- Edge e2: ADD completes. After e2: `res_valid` = 1, state = IDLE, `busy` = 0.
- Edge e3: `res_valid` returns to 0. The earliest next grant is at e3, so with continuous requests the throughput is one result per 3 cycles.
- `res` holds its value until the next ADD or reset. `res_valid` is never high for two consecutive cycles.

## Configuration
- `LC3_ADDR_OVF_EN` defined:
  - Port `res_ovf` exists. It is registered in ADD and pulses together with `res_valid`.
  - It is 1 when base[15] == `ext`[15] and `res`[15] != base[15].
- Not defined: no `res_ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
- r0 alone, base 0x3000, sel 10, off 0x1FF: `r0_ack` pulses after e0, ext 0xFFFF, `res` 0x2FFF with `res_id` 0 and `res_valid` after e2, `busy` high for exactly 2 cycles.
- r1 alone, base 0x0100, sel 11, off 0x400: `res` 0xFD00, `res_id` 1. Then sel 01, off 0x01F: `res` 0x011F.
- Both `req` held after reset, r0 base 0x0010/off 1, r1 base 0x0020/off 2 (sel 00): grants alternate 0,1,0,1; results 0x0011, 0x0022 at 3-cycle spacing; `r1_ack` first seen at e3.
- Wrap and overflow: base 0xFFFF, sel 00, off 0x01 → `res` 0x0000, `res_ovf` 0. Base 0x7FFF, off 0x01 → `res` 0x8000, `res_ovf` 1 (macro on).
- Upper-bit masking: sel 00, off 0x7F0 → ext 0xFFF0. Base 0x0000 → `res` 0xFFF0.
- Assert `rst` during EXT: all outputs go 0 immediately and no `res_valid` appears after release. Both `req` high next → r0 granted first.

Source files
------------

// File: rtl/lc3_offset_addr_arbiter.sv
// Time-shared LC-3 offset sign-extender/adder with round-robin arbitration between two requesters.
// Optional signed-overflow output enabled by defining LC3_ADDR_OVF_EN.
module lc3_offset_addr_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [DATA_W-1:0] r0_base,
  input  logic [10:0]       r0_off,
  input  logic [1:0]        r0_sel,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic [DATA_W-1:0] r1_base,
  input  logic [10:0]       r1_off,
  input  logic [1:0]        r1_sel,
  output logic              r1_ack,
  output logic              busy,
  output logic [DATA_W-1:0] res,
  output logic              res_valid,
  output logic              res_id
`ifdef LC3_ADDR_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;

  logic [1:0]        r_state;
  logic              r_last;
  logic [DATA_W-1:0] r_base;
  logic [10:0]       r_off;
  logic [1:0]        r_sel;
  logic              r_id;
  logic [DATA_W-1:0] r_ext;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_res;
  logic              r_valid;
  logic              r_res_id;

  logic              w_any;
  logic              w_win;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_sum;

  assign w_any = r0_req | r1_req;
  // On a tie the requester that did not win last time goes next.
  assign w_win = (r0_req & r1_req) ? ~r_last : r1_req;

  always_comb begin
    w_ext = '0;
    case (r_sel)
      2'b00:   w_ext = {{(DATA_W-5){r_off[4]}},   r_off[4:0]};
      2'b01:   w_ext = {{(DATA_W-6){r_off[5]}},   r_off[5:0]};
      2'b10:   w_ext = {{(DATA_W-9){r_off[8]}},   r_off[8:0]};
      default: w_ext = {{(DATA_W-11){r_off[10]}}, r_off[10:0]};
    endcase
  end

  assign w_sum = r_base + r_ext;

`ifdef LC3_ADDR_OVF_EN
  logic r_ovf;
  logic w_ovf;
  assign w_ovf   = (r_base[DATA_W-1] == r_ext[DATA_W-1]) &&
                   (w_sum[DATA_W-1] != r_base[DATA_W-1]);
  assign res_ovf = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_base   <= '0;
      r_off    <= '0;
      r_sel    <= '0;
      r_id     <= 1'b0;
      r_ext    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_res    <= '0;
      r_valid  <= 1'b0;
      r_res_id <= 1'b0;
`ifdef LC3_ADDR_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef LC3_ADDR_OVF_EN
      r_ovf   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_base  <= w_win ? r1_base : r0_base;
            r_off   <= w_win ? r1_off  : r0_off;
            r_sel   <= w_win ? r1_sel  : r0_sel;
            r_id    <= w_win;
            r_last  <= w_win;
            r_ack0  <= ~w_win;
            r_ack1  <= w_win;
            r_state <= S_EXT;
          end
        end
        S_EXT: begin
          r_ext   <= w_ext;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_res    <= w_sum;
          r_valid  <= 1'b1;
          r_res_id <= r_id;
`ifdef LC3_ADDR_OVF_EN
          r_ovf    <= w_ovf;
`endif
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r0_ack    = r_ack0;
  assign r1_ack    = r_ack1;
  assign busy      = (r_state != S_IDLE);
  assign res       = r_res;
  assign res_valid = r_valid;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_lc3_offset_addr_arbiter.sv
// Bench for lc3_offset_addr_arbiter: directed literal cases plus randomized traffic against a transaction-level model.
module tb_lc3_offset_addr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [15:0] r0_base = '0, r1_base = '0;
  logic [10:0] r0_off = '0, r1_off = '0;
  logic [1:0]  r0_sel = '0, r1_sel = '0;
  logic        r0_ack, r1_ack, busy, res_valid, res_id;
  logic [15:0] res;
`ifdef LC3_ADDR_OVF_EN
  logic        res_ovf;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  lc3_offset_addr_arbiter #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_base(r0_base), .r0_off(r0_off), .r0_sel(r0_sel), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_base(r1_base), .r1_off(r1_off), .r1_sel(r1_sel), .r1_ack(r1_ack),
    .busy(busy), .res(res), .res_valid(res_valid), .res_id(res_id)
`ifdef LC3_ADDR_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: field width chosen by sel, value treated as a signed integer.
  function automatic int sext_val(input logic [10:0] off, input logic [1:0] sel);
    int w, v;
    w = (sel == 2'd0) ? 5 : (sel == 2'd1) ? 6 : (sel == 2'd2) ? 9 : 11;
    v = int'(off) & ((1 << w) - 1);
    if (v >= (1 << (w - 1))) v = v - (1 << w);
    return v;
  endfunction

  function automatic logic [15:0] ref_res(input logic [15:0] b, input logic [10:0] o, input logic [1:0] s);
    int sum;
    sum = int'(b) + sext_val(o, s);
    return 16'(sum);
  endfunction

  function automatic logic ref_ovf(input logic [15:0] b, input logic [10:0] o, input logic [1:0] s);
    int sb, sum;
    sb  = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    sum = sb + sext_val(o, s);
    return (sum > 32767) || (sum < -32768);
  endfunction

  // Transaction model: m_k counts edges since the grant of the operation in flight (0 = free).
  int          m_k = 0;
  logic        m_last = 1'b1;
  logic [15:0] m_pend_res = '0;
  logic        m_pend_id = 1'b0, m_pend_ovf = 1'b0;
  logic        m_ack0 = 1'b0, m_ack1 = 1'b0, m_busy = 1'b0, m_valid = 1'b0, m_id = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    logic win;
    if (rst) begin
      m_k = 0; m_last = 1'b1;
      m_ack0 = 0; m_ack1 = 0; m_busy = 0; m_valid = 0; m_id = 0; m_ovf = 0; m_res = '0;
    end else begin
      m_ack0 = 0; m_ack1 = 0; m_valid = 0; m_ovf = 0;
      if (m_k == 0) begin
        if (r0_req || r1_req) begin
          win = (r0_req && r1_req) ? ~m_last : r1_req;
          m_last = win;
          m_pend_id  = win;
          m_pend_res = win ? ref_res(r1_base, r1_off, r1_sel) : ref_res(r0_base, r0_off, r0_sel);
          m_pend_ovf = win ? ref_ovf(r1_base, r1_off, r1_sel) : ref_ovf(r0_base, r0_off, r0_sel);
          if (win) m_ack1 = 1; else m_ack0 = 1;
          m_k = 1;
        end
      end else if (m_k == 1) begin
        m_k = 2;
      end else begin
        m_k = 0;
        m_valid = 1; m_res = m_pend_res; m_id = m_pend_id; m_ovf = m_pend_ovf;
      end
      m_busy = (m_k != 0);
    end
  end

  always @(negedge clk) begin
    chk("m_r0_ack", 16'(r0_ack), 16'(m_ack0));
    chk("m_r1_ack", 16'(r1_ack), 16'(m_ack1));
    chk("m_busy", 16'(busy), 16'(m_busy));
    chk("m_res_valid", 16'(res_valid), 16'(m_valid));
    chk("m_res", res, m_res);
    chk("m_res_id", 16'(res_id), 16'(m_id));
`ifdef LC3_ADDR_OVF_EN
    chk("m_res_ovf", 16'(res_ovf), 16'(m_ovf));
`endif
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run1(input logic id, input logic [15:0] b, input logic [10:0] o, input logic [1:0] s,
                      input logic [15:0] exp_res, input logic exp_ovf, input string nm);
    if (id) begin r1_base = b; r1_off = o; r1_sel = s; r1_req = 1'b1; end
    else    begin r0_base = b; r0_off = o; r0_sel = s; r0_req = 1'b1; end
    chk({nm, "_busy_pre"}, 16'(busy), 16'd0);
    @(posedge clk); #1;
    chk({nm, "_ack"}, 16'(id ? r1_ack : r0_ack), 16'd1);
    chk({nm, "_busy_e0"}, 16'(busy), 16'd1);
    r0_req = 1'b0; r1_req = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_ack_clr"}, 16'(id ? r1_ack : r0_ack), 16'd0);
    chk({nm, "_busy_e1"}, 16'(busy), 16'd1);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 16'(res_valid), 16'd1);
    chk({nm, "_res"}, res, exp_res);
    chk({nm, "_id"}, 16'(res_id), 16'(id));
    chk({nm, "_busy_e2"}, 16'(busy), 16'd0);
`ifdef LC3_ADDR_OVF_EN
    chk({nm, "_ovf"}, 16'(res_ovf), 16'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 16'(res_valid), 16'd0);
    chk({nm, "_res_hold"}, res, exp_res);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst_res", res, 16'h0000);
    chk("rst_busy", 16'(busy), 16'd0);

    run1(1'b0, 16'h3000, 11'h1FF, 2'b10, 16'h2FFF, 1'b0, "r0_pc9");
    run1(1'b1, 16'h0100, 11'h400, 2'b11, 16'hFD00, 1'b0, "r1_pc11");
    run1(1'b1, 16'h0100, 11'h01F, 2'b01, 16'h011F, 1'b0, "r1_off6");
    run1(1'b0, 16'hFFFF, 11'h001, 2'b00, 16'h0000, 1'b0, "wrap");
    run1(1'b0, 16'h7FFF, 11'h001, 2'b00, 16'h8000, 1'b1, "ovf");
    run1(1'b1, 16'h0000, 11'h7F0, 2'b00, 16'hFFF0, 1'b0, "mask");

    // Tie: both held continuously, grants alternate starting with r0.
    do_reset();
    r0_base = 16'h0010; r0_off = 11'd1; r0_sel = 2'b00;
    r1_base = 16'h0020; r1_off = 11'd2; r1_sel = 2'b00;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 1) begin
        chk($sformatf("tie_r0_ack_c%0d", c), 16'(r0_ack), 16'(((c / 3) % 2) == 0));
        chk($sformatf("tie_r1_ack_c%0d", c), 16'(r1_ack), 16'(((c / 3) % 2) == 1));
      end
      if (c % 3 == 0) begin
        chk($sformatf("tie_valid_c%0d", c), 16'(res_valid), 16'd1);
        chk($sformatf("tie_res_c%0d", c), res, (((c / 3) % 2) == 1) ? 16'h0011 : 16'h0022);
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    @(posedge clk); #1;

    // Reset during EXT after an r0 grant; last must return to 1 so r0 wins the following tie.
    r0_base = 16'h1234; r0_off = 11'h005; r0_sel = 2'b00; r0_req = 1'b1;
    @(posedge clk); #1;
    r0_req = 1'b0;
    chk("mid_ack", 16'(r0_ack), 16'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ack", 16'(r0_ack), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_res", res, 16'h0000);
    chk("mid_rst_valid", 16'(res_valid), 16'd0);
    chk("mid_rst_id", 16'(res_id), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_novalid", 16'(res_valid), 16'd0);
    end
    r0_req = 1'b1; r1_req = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_r0_first", 16'(r0_ack), 16'd1);
    chk("post_rst_r1_wait", 16'(r1_ack), 16'd0);
    r0_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_r1_next", 16'(r1_ack), 16'd1);
    r1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic; operands change freely once a request is off the bus.
    for (int c = 0; c < 3000; c++) begin
      if (r0_req && r0_ack) r0_req = 1'b0;
      else if (!r0_req) begin
        r0_base = 16'($urandom); r0_off = 11'($urandom); r0_sel = 2'($urandom);
        if ($urandom_range(0, 2) == 0) r0_req = 1'b1;
      end
      if (r1_req && r1_ack) r1_req = 1'b0;
      else if (!r1_req) begin
        r1_base = 16'($urandom); r1_off = 11'($urandom); r1_sel = 2'($urandom);
        if ($urandom_range(0, 2) == 0) r1_req = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
